// File: rtl/cache_read_requester.sv
// Per-client read front-end for one cache bank arbiter read input: in-order request queue,
// credit-gated issue, fixed 2-cycle return tracking and a valid/ready response FIFO.

package cache_read_requester_pkg;
  typedef struct packed {
    logic        ce;
    logic [31:0] addr;
  } cache_if_t;
endpackage

module cache_read_requester #(
  parameter type         IF_t       = cache_read_requester_pkg::cache_if_t,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned REQ_DEPTH  = 4,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IN_flush,
  input  logic                  IN_reqValid,
  output logic                  OUT_reqReady,
  input  IF_t                   IN_req,
  input  logic [TAG_WIDTH-1:0]  IN_reqTag,
  output IF_t                   OUT_read,
  input  logic                  IN_readReady,
  input  logic [DATA_WIDTH-1:0] IN_readData,
  output logic                  OUT_rspValid,
  input  logic                  IN_rspReady,
  output logic [DATA_WIDTH-1:0] OUT_rspData,
  output logic [TAG_WIDTH-1:0]  OUT_rspTag
);

  localparam int unsigned ReqPtrW = $clog2(REQ_DEPTH);
  localparam int unsigned ReqCntW = ReqPtrW + 1;
  localparam int unsigned RspPtrW = $clog2(RSP_DEPTH);
  localparam int unsigned RspCntW = RspPtrW + 1;
  localparam int unsigned CreditW = RspCntW + 1;

  // Request queue
  IF_t                  req_mem_q [REQ_DEPTH];
  logic [TAG_WIDTH-1:0] req_tag_q [REQ_DEPTH];
  logic [ReqPtrW-1:0]   req_wr_ptr_q, req_wr_ptr_d;
  logic [ReqPtrW-1:0]   req_rd_ptr_q, req_rd_ptr_d;
  logic [ReqCntW-1:0]   req_cnt_q, req_cnt_d;

  // In-flight return pipeline
  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

  // Response FIFO
  logic [DATA_WIDTH-1:0] rsp_data_q [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]  rsp_tag_q  [RSP_DEPTH];
  logic [RspPtrW-1:0]    rsp_wr_ptr_q, rsp_wr_ptr_d;
  logic [RspPtrW-1:0]    rsp_rd_ptr_q, rsp_rd_ptr_d;
  logic [RspCntW-1:0]    rsp_cnt_q, rsp_cnt_d;

  logic               req_push;
  logic               head_valid;
  logic [1:0]         inflight_cnt;
  logic [CreditW-1:0] committed;
  logic               credit;
  logic               read_en;
  logic               grant;
  logic               capture;
  logic               rsp_pop;

  assign OUT_reqReady = (req_cnt_q != ReqCntW'(REQ_DEPTH));
  assign req_push     = IN_reqValid && OUT_reqReady && !IN_flush;
  assign head_valid   = (req_cnt_q != '0);

  // Every response slot already promised to a granted read counts against the FIFO.
  assign inflight_cnt = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
  assign committed    = CreditW'(rsp_cnt_q) + CreditW'(inflight_cnt);
  assign credit       = (committed < CreditW'(RSP_DEPTH));
  assign read_en      = head_valid && credit && !IN_flush;
  assign grant        = read_en && IN_readReady;

  always_comb begin
    OUT_read    = req_mem_q[req_rd_ptr_q];
    OUT_read.ce = !read_en;
  end

  assign capture      = s2_valid_q && !IN_flush;
  assign OUT_rspValid = (rsp_cnt_q != '0);
  assign rsp_pop      = OUT_rspValid && IN_rspReady;
  assign OUT_rspData  = OUT_rspValid ? rsp_data_q[rsp_rd_ptr_q] : '0;
  assign OUT_rspTag   = OUT_rspValid ? rsp_tag_q[rsp_rd_ptr_q] : '0;

  always_comb begin
    req_wr_ptr_d = req_wr_ptr_q;
    req_rd_ptr_d = req_rd_ptr_q;
    req_cnt_d    = req_cnt_q;
    if (IN_flush) begin
      req_wr_ptr_d = '0;
      req_rd_ptr_d = '0;
      req_cnt_d    = '0;
    end else begin
      if (req_push) req_wr_ptr_d = req_wr_ptr_q + ReqPtrW'(1);
      if (grant)    req_rd_ptr_d = req_rd_ptr_q + ReqPtrW'(1);
      unique case ({req_push, grant})
        2'b10:   req_cnt_d = req_cnt_q + ReqCntW'(1);
        2'b01:   req_cnt_d = req_cnt_q - ReqCntW'(1);
        default: req_cnt_d = req_cnt_q;
      endcase
    end
  end

  always_comb begin
    s1_valid_d = grant;
    s1_tag_d   = req_tag_q[req_rd_ptr_q];
    s2_valid_d = s1_valid_q && !IN_flush;
    s2_tag_d   = s1_tag_q;
  end

  always_comb begin
    rsp_wr_ptr_d = rsp_wr_ptr_q;
    rsp_rd_ptr_d = rsp_rd_ptr_q;
    rsp_cnt_d    = rsp_cnt_q;
    if (IN_flush) begin
      rsp_wr_ptr_d = '0;
      rsp_rd_ptr_d = '0;
      rsp_cnt_d    = '0;
    end else begin
      if (capture) rsp_wr_ptr_d = rsp_wr_ptr_q + RspPtrW'(1);
      if (rsp_pop) rsp_rd_ptr_d = rsp_rd_ptr_q + RspPtrW'(1);
      unique case ({capture, rsp_pop})
        2'b10:   rsp_cnt_d = rsp_cnt_q + RspCntW'(1);
        2'b01:   rsp_cnt_d = rsp_cnt_q - RspCntW'(1);
        default: rsp_cnt_d = rsp_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr_ptr_q <= '0;
      req_rd_ptr_q <= '0;
      req_cnt_q    <= '0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      s2_tag_q     <= '0;
      rsp_wr_ptr_q <= '0;
      rsp_rd_ptr_q <= '0;
      rsp_cnt_q    <= '0;
    end else begin
      req_wr_ptr_q <= req_wr_ptr_d;
      req_rd_ptr_q <= req_rd_ptr_d;
      req_cnt_q    <= req_cnt_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s1_tag_q     <= s1_tag_d;
      s2_tag_q     <= s2_tag_d;
      rsp_wr_ptr_q <= rsp_wr_ptr_d;
      rsp_rd_ptr_q <= rsp_rd_ptr_d;
      rsp_cnt_q    <= rsp_cnt_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_push) begin
      req_mem_q[req_wr_ptr_q] <= IN_req;
      req_tag_q[req_wr_ptr_q] <= IN_reqTag;
    end
    if (capture) begin
      rsp_data_q[rsp_wr_ptr_q] <= IN_readData;
      rsp_tag_q[rsp_wr_ptr_q]  <= s2_tag_q;
    end
  end

endmodule
